// File: rtl/pc_unit.sv
// Program counter with branch/jump redirect, pipeline stall, single-step debug mode
// and a sticky halt state. Also counts the PC updates retired since reset.
module pc_unit #(
    parameter int                NB_PC    = 32,
    parameter int                PC_INC   = 4,
    parameter logic [NB_PC-1:0]  RESET_PC = '0,
    parameter int                NB_CNT   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_PC_write,
    input  logic              i_branch,
    input  logic [NB_PC-1:0]  i_branch_target,
    input  logic              i_jump,
    input  logic [NB_PC-1:0]  i_jump_target,
    input  logic              i_halt,
    input  logic              i_step_mode,
    input  logic              i_step,
    output logic [NB_PC-1:0]  o_PC,
    output logic [NB_PC-1:0]  o_PC_inc,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_upd_count
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STEP_IDLE,
        ST_HALTED
    } state_t;

    localparam logic [NB_PC-1:0] INC = NB_PC'(PC_INC);

    state_t             r_state;
    logic [NB_PC-1:0]   r_pc;
    logic [NB_CNT-1:0]  r_cnt;
    logic               r_halted;
    logic               r_step_prev;

    logic               w_step_edge;
    logic               w_advance;
    logic               w_update;
    logic [NB_PC-1:0]   w_pc_inc;
    logic [NB_PC-1:0]   w_next_pc;

    assign w_pc_inc    = r_pc + INC;
    assign w_step_edge = i_step & ~r_step_prev;
    assign w_advance   = (r_state == ST_RUN) ||
                         ((r_state == ST_STEP_IDLE) && w_step_edge);
    // Halt wins over any update requested in the same cycle.
    assign w_update    = (r_state != ST_HALTED) && !i_halt && i_PC_write && w_advance;

    always_comb begin
        if (i_branch)
            w_next_pc = i_branch_target;
        else if (i_jump)
            w_next_pc = i_jump_target;
        else
            w_next_pc = w_pc_inc;
    end

    // NOTE: asynchronous reset in the sensitivity list; all state uses non-blocking <=
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_cnt       <= '0;
            r_halted    <= 1'b0;
            r_step_prev <= 1'b0;
        end else if (r_state != ST_HALTED) begin
            r_step_prev <= i_step;
            if (i_halt) begin
                r_state  <= ST_HALTED;
                r_halted <= 1'b1;
            end else begin
                if (w_update) begin
                    r_pc  <= w_next_pc;
                    r_cnt <= r_cnt + NB_CNT'(1);
                end
                // Mode change takes effect next cycle; this cycle used the old rule.
                r_state <= i_step_mode ? ST_STEP_IDLE : ST_RUN;
            end
        end
    end

    assign o_PC        = r_pc;
    assign o_PC_inc    = w_pc_inc;
    assign o_halted    = r_halted;
    assign o_upd_count = r_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a 32-bit and an 8-bit instance share stimulus and
// are compared against a rule-level reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_write = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] bt = '0;
    logic        jump = 1'b0;
    logic [31:0] jt = '0;
    logic        halt = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;

    logic [31:0] o_pc, o_pc_inc, o_cnt;
    logic        o_halted;
    logic [7:0]  o_pc8, o_pc8_inc;
    logic [31:0] o_cnt8;
    logic        o_halted8;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [7:0]  m_pc8;
    logic [31:0] m_cnt;
    bit          m_halted;
    bit          m_stepping;
    bit          m_prev;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .rst(rst), .i_PC_write(pc_write),
        .i_branch(branch), .i_branch_target(bt),
        .i_jump(jump), .i_jump_target(jt),
        .i_halt(halt), .i_step_mode(step_mode), .i_step(step),
        .o_PC(o_pc), .o_PC_inc(o_pc_inc), .o_halted(o_halted), .o_upd_count(o_cnt)
    );

    pc_unit #(.NB_PC(8)) dut8 (
        .clk(clk), .rst(rst), .i_PC_write(pc_write),
        .i_branch(branch), .i_branch_target(bt[7:0]),
        .i_jump(jump), .i_jump_target(jt[7:0]),
        .i_halt(halt), .i_step_mode(step_mode), .i_step(step),
        .o_PC(o_pc8), .o_PC_inc(o_pc8_inc), .o_halted(o_halted8), .o_upd_count(o_cnt8)
    );

    task automatic model_reset();
        m_pc = 0; m_pc8 = 0; m_cnt = 0;
        m_halted = 0; m_stepping = 0; m_prev = 0;
    endtask

    // Applies the behavioural rules for one clock edge using the current inputs.
    task automatic model_edge();
        bit may_advance;
        if (m_halted) return;
        if (halt) begin
            m_halted = 1;
        end else begin
            may_advance = !m_stepping || (step && !m_prev);
            if (pc_write && may_advance) begin
                if (branch) begin
                    m_pc = bt; m_pc8 = bt[7:0];
                end else if (jump) begin
                    m_pc = jt; m_pc8 = jt[7:0];
                end else begin
                    m_pc = m_pc + 4; m_pc8 = m_pc8 + 8'd4;
                end
                m_cnt = m_cnt + 1;
            end
            m_stepping = step_mode;
        end
        m_prev = step;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_write = 0; branch = 0; jump = 0; halt = 0;
        step_mode = 0; step = 0; bt = '0; jt = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        #2;
        model_reset();
        rst = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #3;
        model_reset();
        total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", o_pc, 32'h0); end
        total++; if (o_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=%h", o_cnt, 32'h0); end
        total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", o_halted); end
        total++; if (o_pc_inc !== 32'h4) begin bad++; $display("FAIL reset_pc_inc got=%h exp=%h", o_pc_inc, 32'h4); end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_run();
        pc_write = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (o_pc !== 32'(i * 4)) begin bad++; $display("FAIL run_pc[%0d] got=%h exp=%h", i, o_pc, 32'(i * 4)); end
        end
        total++; if (o_cnt !== 32'd3) begin bad++; $display("FAIL run_cnt got=%0d exp=3", o_cnt); end
    endtask

    task automatic test_priority();
        pc_write = 0; branch = 1; bt = 32'h100;
        tick();
        total++; if (o_pc !== 32'hC) begin bad++; $display("FAIL stall_pc got=%h exp=%h", o_pc, 32'hC); end
        total++; if (o_cnt !== 32'd3) begin bad++; $display("FAIL stall_cnt got=%0d exp=3", o_cnt); end
        pc_write = 1; jump = 1; jt = 32'h200;
        tick();
        total++; if (o_pc !== 32'h100) begin bad++; $display("FAIL branch_over_jump got=%h exp=%h", o_pc, 32'h100); end
        branch = 0;
        tick();
        total++; if (o_pc !== 32'h200) begin bad++; $display("FAIL jump_pc got=%h exp=%h", o_pc, 32'h200); end
        total++; if (o_cnt !== 32'd5) begin bad++; $display("FAIL priority_cnt got=%0d exp=5", o_cnt); end
        jump = 0;
    endtask

    task automatic test_wrap();
        pc_write = 1; jump = 1; jt = 32'hFC;
        tick();
        jump = 0;
        total++; if (o_pc8 !== 8'hFC) begin bad++; $display("FAIL wrap_load got=%h exp=%h", o_pc8, 8'hFC); end
        total++; if (o_pc8_inc !== 8'h00) begin bad++; $display("FAIL wrap_inc_at_fc got=%h exp=%h", o_pc8_inc, 8'h00); end
        tick();
        total++; if (o_pc8 !== 8'h00) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", o_pc8, 8'h00); end
        total++; if (o_pc8_inc !== 8'h04) begin bad++; $display("FAIL wrap_pc_inc got=%h exp=%h", o_pc8_inc, 8'h04); end
        total++; if (o_pc !== 32'h100) begin bad++; $display("FAIL wide_no_wrap got=%h exp=%h", o_pc, 32'h100); end
    endtask

    task automatic test_step();
        logic [31:0] c0;
        logic [31:0] p0;
        p0 = o_pc;
        pc_write = 1; step_mode = 1; step = 0;
        tick();
        total++; if (o_pc !== p0 + 32'd4) begin bad++; $display("FAIL mode_change_update got=%h exp=%h", o_pc, p0 + 32'd4); end
        c0 = o_cnt;
        tick();
        total++; if (o_cnt !== c0) begin bad++; $display("FAIL step_idle_hold got=%0d exp=%0d", o_cnt, c0); end
        step = 1;
        for (int i = 0; i < 5; i++) tick();
        total++; if (o_cnt !== c0 + 1) begin bad++; $display("FAIL step_held_once got=%0d exp=%0d", o_cnt, c0 + 1); end
        total++; if (o_pc !== m_pc) begin bad++; $display("FAIL step_pc got=%h exp=%h", o_pc, m_pc); end
        step = 0;
        tick();
        step = 1;
        tick();
        total++; if (o_cnt !== c0 + 2) begin bad++; $display("FAIL step_second got=%0d exp=%0d", o_cnt, c0 + 2); end
        total++; if (o_pc !== p0 + 32'd12) begin bad++; $display("FAIL step_second_pc got=%h exp=%h", o_pc, p0 + 32'd12); end
        step = 0; step_mode = 0;
        tick();
        tick();
        total++; if (o_cnt !== m_cnt) begin bad++; $display("FAIL step_exit_cnt got=%0d exp=%0d", o_cnt, m_cnt); end
    endtask

    task automatic test_halt();
        logic [31:0] c0;
        do_reset();
        @(negedge clk);
        pc_write = 1; jump = 1; jt = 32'h20;
        tick();
        total++; if (o_pc !== 32'h20) begin bad++; $display("FAIL halt_setup got=%h exp=%h", o_pc, 32'h20); end
        c0 = o_cnt;
        jt = 32'h40; halt = 1;
        tick();
        total++; if (o_pc !== 32'h20) begin bad++; $display("FAIL halt_pc got=%h exp=%h", o_pc, 32'h20); end
        total++; if (o_halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", o_halted); end
        for (int i = 0; i < 10; i++) begin
            halt = 1'($urandom); pc_write = 1'($urandom); branch = 1'($urandom);
            jump = 1'($urandom); step = 1'($urandom); step_mode = 1'($urandom);
            bt = $urandom; jt = $urandom;
            tick();
            total++;
            if (o_pc !== 32'h20 || o_cnt !== c0 || o_halted !== 1'b1) begin
                bad++;
                $display("FAIL halt_sticky[%0d] got pc=%h cnt=%0d h=%b exp pc=20 cnt=%0d h=1",
                         i, o_pc, o_cnt, o_halted, c0);
            end
        end
    endtask

    task automatic test_reset_halted();
        #3;
        rst = 0;
        #1;
        total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL rst_halted_pc got=%h exp=0", o_pc); end
        total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL rst_halted_flag got=%b exp=0", o_halted); end
        total++; if (o_cnt !== 32'h0) begin bad++; $display("FAIL rst_halted_cnt got=%0d exp=0", o_cnt); end
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1;
        pc_write = 1;
        tick();
        total++; if (o_pc !== 32'h4) begin bad++; $display("FAIL resume_after_rst got=%h exp=4", o_pc); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            @(negedge clk);
            for (int i = 0; i < 120; i++) begin
                pc_write  = ($urandom_range(0, 3) != 0);
                branch    = ($urandom_range(0, 4) == 0);
                jump      = ($urandom_range(0, 4) == 0);
                bt        = $urandom;
                jt        = $urandom;
                halt      = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
                step      = 1'($urandom);
                tick();
                total++;
                if (o_pc !== m_pc || o_pc_inc !== m_pc + 32'd4 || o_cnt !== m_cnt ||
                    o_halted !== m_halted || o_pc8 !== m_pc8 || o_cnt8 !== m_cnt) begin
                    bad++;
                    $display("FAIL random[%0d.%0d] got pc=%h inc=%h cnt=%0d h=%b pc8=%h exp pc=%h inc=%h cnt=%0d h=%b pc8=%h",
                             r, i, o_pc, o_pc_inc, o_cnt, o_halted, o_pc8,
                             m_pc, m_pc + 32'd4, m_cnt, m_halted, m_pc8);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run();
        test_priority();
        test_wrap();
        test_step();
        test_halt();
        test_reset_halted();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter NB_PC, default 32, giving the PC width in bits.
REQ-002 The block SHALL have parameter PC_INC, default 4, giving the sequential increment.
REQ-003 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-004 The block SHALL have parameter NB_CNT, default 32, giving the retired-update counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port i_PC_write, input, 1 bit: PC update enable; 0 means pipeline stall.
REQ-008 The block SHALL have port i_branch, input, 1 bit: taken branch resolved downstream.
REQ-009 The block SHALL have port i_branch_target, input, NB_PC bits: branch destination.
REQ-010 The block SHALL have port i_jump, input, 1 bit: jump decoded.
REQ-011 The block SHALL have port i_jump_target, input, NB_PC bits: jump destination.
REQ-012 The block SHALL have port i_halt, input, 1 bit: halt instruction reached.
REQ-013 The block SHALL have port i_step_mode, input, 1 bit: 1 selects single-step execution.
REQ-014 The block SHALL have port i_step, input, 1 bit: step request, level signal from the debug unit.
REQ-015 The block SHALL have port o_PC, output, NB_PC bits: current PC register.
REQ-016 The block SHALL have port o_PC_inc, output, NB_PC bits: o_PC + PC_INC, combinational.
REQ-017 The block SHALL have port o_halted, output, 1 bit: halt state flag.
REQ-018 The block SHALL have port o_upd_count, output, NB_CNT bits: number of PC updates since reset.

Function
REQ-019 The block SHALL implement the state machine RUN, STEP_IDLE, HALTED.
REQ-020 The block SHALL perform a PC update in a cycle only if the state is not HALTED, i_PC_write=1, and an advance is permitted.
REQ-021 The block SHALL permit an advance when the state is RUN, or when the state is STEP_IDLE and a rising edge of i_step is detected.
REQ-022 The block SHALL detect an i_step rising edge as i_step=1 with the registered previous i_step=0; each step edge SHALL yield at most one update.
REQ-023 The block SHALL select the next PC with priority i_branch (i_branch_target) > i_jump (i_jump_target) > sequential (o_PC + PC_INC).
REQ-024 The block SHALL load the new o_PC on the clock edge of the update cycle, with one-cycle latency from input to o_PC.
REQ-025 The block SHALL compute sequential increments modulo 2^NB_PC, wrapping silently with no flag.
REQ-026 The block SHALL use target values unmodified, with no alignment masking.
REQ-027 The block SHALL hold o_PC unchanged on a stall (i_PC_write=0) regardless of i_branch or i_jump, so redirects are lost unless held by the requester.
REQ-028 The block SHALL increment o_upd_count by 1 on every PC update, wrapping modulo 2^NB_CNT.
REQ-029 The block SHALL move to HALTED at the next edge whenever i_halt=1 and the state is not HALTED, with no PC update in that cycle; i_halt SHALL take precedence over branch, jump and step.
REQ-030 The block SHALL keep HALTED sticky until reset: o_PC, o_upd_count frozen, o_halted=1, all inputs ignored.
REQ-031 The block SHALL, outside HALTED, enter STEP_IDLE when i_step_mode=1 and RUN when i_step_mode=0, both at the next edge.
REQ-032 The block SHALL, on a mode change in the same cycle as an update, perform the update under the current state's rule.

Reset
REQ-033 The block SHALL, while rst=0, asynchronously force o_PC=RESET_PC, o_upd_count=0, o_halted=0, state=RUN, and registered step=0.
REQ-034 The block SHALL resume updates on the first rising edge after rst deasserts, when allowed by REQ-020.
REQ-035 The block SHALL, on reset asserted mid-operation including HALTED or STEP_IDLE, abort immediately with no partial update.

Verification
REQ-036 Verification SHALL cover reset then run: rst 0->1, i_PC_write=1 for 3 cycles -> o_PC 0,4,8,12; o_upd_count=3.
REQ-037 Verification SHALL cover stall and priority: i_PC_write=0 with i_branch=1 -> o_PC held. i_PC_write=1, i_branch=1 (target 0x100), i_jump=1 (target 0x200) -> o_PC=0x100.
REQ-038 Verification SHALL cover wrap: NB_PC=8, o_PC=0xFC -> next o_PC=0x00 and o_PC_inc=0x04.
REQ-039 Verification SHALL cover step mode: i_step_mode=1, i_step held high 5 cycles -> exactly one update. i_step low then high again -> one more update.
REQ-040 Verification SHALL cover halt: i_halt=1 at o_PC=0x20 with i_jump=1 -> o_PC stays 0x20, o_halted=1 next cycle, unchanged for 10 cycles.
REQ-041 Verification SHALL cover reset in HALTED: rst pulse low mid-cycle -> immediately o_PC=RESET_PC, o_halted=0, o_upd_count=0.
